// File: rtl/rf_pkg.sv
// Register-file constants shared by the writeback arbiter and its sub-blocks.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam logic [AW-1:0] X0_ADDR = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) gets the one-hot grant.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    // Scan positions ptr, ptr+1, ... and grant only the first one holding a request.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among writeback sources and tracks
// destinations with a pending write so issue can stall on RAW/WAW hazards.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    alloc_valid,
    input  logic [AW-1:0]           alloc_rd,
    output logic [AW-1:0]           rf_a3,
    output logic [XLEN-1:0]         rf_wd,
    output logic                    wb_valid,
    output logic [NUM_REGS-1:0]     busy,
    output logic                    err_waw
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       sel;
    logic [NUM_REQ-1:0]  grant;
    logic                transfer;
    logic [AW-1:0]       sel_rd;
    logic [XLEN-1:0]     sel_data;
    logic [NUM_REGS-1:0] busy_next;
    logic                waw_hit;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = res ? '0 : grant;
    assign transfer  = |(req_valid & req_ready);

    always_comb begin
        sel      = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel      = PW'(i);
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // The retiring write clears its bit first so a same-cycle re-allocation of that register wins.
    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[rf_a3] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != X0_ADDR)) begin
            busy_next[alloc_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign waw_hit = alloc_valid && (alloc_rd != X0_ADDR) && busy[alloc_rd]
                     && !(wb_valid && (rf_a3 == alloc_rd));

    // x0 writes are accepted but leave the port idle so the write-every-cycle RF stays safe.
    always_ff @(posedge clk) begin
        if (res) begin
            rr_ptr   <= '0;
            rf_a3    <= '0;
            rf_wd    <= '0;
            wb_valid <= 1'b0;
            busy     <= '0;
            err_waw  <= 1'b0;
        end else begin
            if (transfer) begin
                rr_ptr <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
            if (transfer && (sel_rd != X0_ADDR)) begin
                rf_a3    <= sel_rd;
                rf_wd    <= sel_data;
                wb_valid <= 1'b1;
            end else begin
                rf_a3    <= '0;
                rf_wd    <= '0;
                wb_valid <= 1'b0;
            end
            busy <= busy_next;
            if (waw_hit) begin
                err_waw <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        res;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        wb_valid;
    logic [31:0] busy;
    logic        err_waw;

    int checks   = 0;
    int failures = 0;

    bit          sValid [3];
    logic [4:0]  sRd    [3];
    logic [31:0] sData  [3];
    bit          aValid;
    logic [4:0]  aRd;
    bit          resIn;

    int          mPtr;
    bit [31:0]   mBusy;
    logic [4:0]  mA3;
    logic [31:0] mWd;
    bit          mWv;
    bit          mErr;
    bit          regsKnown;
    int          g;

    rf_wb_arbiter #(.NUM_REQ(3)) dut (
        .clk         (clk),
        .res         (res),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd),
        .wb_valid    (wb_valid),
        .busy        (busy),
        .err_waw     (err_waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        res = resIn;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]        = sValid[i];
            req_rd[i*5 +: 5]    = sRd[i];
            req_data[i*32 +: 32] = sData[i];
        end
        alloc_valid = aValid;
        alloc_rd    = aRd;
    endtask

    // One clock: drive, compare every output with the model, then advance the model across the posedge.
    task automatic stepCycle(output int granted);
        bit [31:0] nextBusy;
        logic [31:0] expReady;
        int gg;
        @(negedge clk);
        applyStimulus();
        #1;
        gg = -1;
        if (!resIn) begin
            for (int k = 0; k < 3; k++) begin
                if (gg < 0 && sValid[(mPtr + k) % 3]) gg = (mPtr + k) % 3;
            end
        end
        expReady = (gg >= 0) ? (32'd1 << gg) : 32'd0;
        checkOutput("req_ready", {29'd0, req_ready}, expReady);
        if (regsKnown) begin
            checkOutput("rf_a3", {27'd0, rf_a3}, {27'd0, mA3});
            checkOutput("rf_wd", rf_wd, mWd);
            checkOutput("wb_valid", {31'd0, wb_valid}, {31'd0, mWv});
            checkOutput("busy", busy, mBusy);
            checkOutput("err_waw", {31'd0, err_waw}, {31'd0, mErr});
        end
        if (resIn) begin
            mPtr = 0; mBusy = '0; mA3 = '0; mWd = '0; mWv = 0; mErr = 0;
            regsKnown = 1;
        end else begin
            nextBusy = mBusy;
            if (mWv) nextBusy[mA3] = 1'b0;
            if (aValid && aRd != 5'd0) begin
                if (mBusy[aRd] && !(mWv && mA3 == aRd)) mErr = 1;
                nextBusy[aRd] = 1'b1;
            end
            nextBusy[0] = 1'b0;
            if (gg >= 0 && sRd[gg] != 5'd0) begin
                mA3 = sRd[gg]; mWd = sData[gg]; mWv = 1;
            end else begin
                mA3 = '0; mWd = '0; mWv = 0;
            end
            if (gg >= 0) mPtr = (gg + 1) % 3;
            mBusy = nextBusy;
        end
        granted = gg;
    endtask

    task automatic idleSources();
        for (int i = 0; i < 3; i++) begin
            sValid[i] = 0; sRd[i] = '0; sData[i] = '0;
        end
        aValid = 0; aRd = '0;
    endtask

    initial begin
        regsKnown = 0;
        mPtr = 0; mBusy = '0; mA3 = '0; mWd = '0; mWv = 0; mErr = 0;
        idleSources();
        resIn = 1;
        applyStimulus();

        // Reset held two cycles with every source requesting
        for (int i = 0; i < 3; i++) begin
            sValid[i] = 1; sRd[i] = 5'(i + 1); sData[i] = $urandom;
        end
        repeat (2) begin
            stepCycle(g);
            checkOutput("rst_ready", {29'd0, req_ready}, 32'd0);
        end
        resIn = 0;

        // Round-robin with all sources continuously valid; first grant proves rr_ptr=0
        for (int k = 0; k < 6; k++) begin
            stepCycle(g);
            checkOutput("rr_grant", {29'd0, req_ready}, 32'd1 << (k % 3));
            if (k == 0) begin
                checkOutput("rst_a3", {27'd0, rf_a3}, 32'd0);
                checkOutput("rst_wd", rf_wd, 32'd0);
                checkOutput("rst_busy", busy, 32'd0);
            end else begin
                checkOutput("rr_wb", {31'd0, wb_valid}, 32'd1);
            end
            if (g >= 0) begin
                sRd[g] = 5'($urandom_range(1, 31)); sData[g] = $urandom;
            end
        end
        idleSources();
        stepCycle(g);

        // Single write
        sValid[0] = 1; sRd[0] = 5'd5; sData[0] = 32'hDEADBEEF;
        stepCycle(g);
        sValid[0] = 0;
        stepCycle(g);
        checkOutput("single_a3", {27'd0, rf_a3}, 32'd5);
        checkOutput("single_wd", rf_wd, 32'hDEADBEEF);
        checkOutput("single_wv", {31'd0, wb_valid}, 32'd1);
        stepCycle(g);
        checkOutput("single_a3_idle", {27'd0, rf_a3}, 32'd0);
        checkOutput("single_wd_idle", rf_wd, 32'd0);

        // Scoreboard timing: alloc 7 at t0, source 1 writes 7 at t3
        aValid = 1; aRd = 5'd7;
        stepCycle(g);
        aValid = 0;
        for (int t = 1; t <= 5; t++) begin
            if (t == 3) begin
                sValid[1] = 1; sRd[1] = 5'd7; sData[1] = 32'hA5A5_0007;
            end
            stepCycle(g);
            sValid[1] = 0;
            checkOutput("sb_busy7", {31'd0, busy[7]}, (t <= 4) ? 32'd1 : 32'd0);
        end

        // Collision: re-alloc 9 in the cycle its write retires, then a true WAW
        aValid = 1; aRd = 5'd9;
        stepCycle(g);
        aValid = 0;
        sValid[2] = 1; sRd[2] = 5'd9; sData[2] = 32'h0000_0909;
        stepCycle(g);
        sValid[2] = 0;
        aValid = 1; aRd = 5'd9;
        stepCycle(g);
        checkOutput("col_wv", {31'd0, wb_valid}, 32'd1);
        stepCycle(g);
        checkOutput("col_busy9", {31'd0, busy[9]}, 32'd1);
        checkOutput("col_err0", {31'd0, err_waw}, 32'd0);
        aValid = 0;
        repeat (2) begin
            stepCycle(g);
            checkOutput("waw_sticky", {31'd0, err_waw}, 32'd1);
        end

        // x0 request is accepted but produces no write
        sValid[2] = 1; sRd[2] = 5'd0; sData[2] = 32'h1234;
        stepCycle(g);
        checkOutput("x0_ready", {29'd0, req_ready}, 32'd4);
        sValid[2] = 0;
        stepCycle(g);
        checkOutput("x0_wd", rf_wd, 32'd0);
        checkOutput("x0_wv", {31'd0, wb_valid}, 32'd0);

        // Reset the cycle after a transfer
        aValid = 1; aRd = 5'd12;
        stepCycle(g);
        aValid = 0;
        sValid[0] = 1; sRd[0] = 5'd12; sData[0] = 32'hCAFE_0012;
        stepCycle(g);
        sValid[0] = 0;
        resIn = 1;
        stepCycle(g);
        resIn = 0;
        stepCycle(g);
        checkOutput("midrst_a3", {27'd0, rf_a3}, 32'd0);
        checkOutput("midrst_wv", {31'd0, wb_valid}, 32'd0);
        checkOutput("midrst_busy", busy, 32'd0);

        // Random traffic; sources hold their request until granted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!sValid[i] && ($urandom_range(0, 2) != 0)) begin
                    sValid[i] = 1; sRd[i] = 5'($urandom_range(0, 7)); sData[i] = $urandom;
                end
            end
            aValid = ($urandom_range(0, 2) == 0);
            aRd    = 5'($urandom_range(0, 7));
            resIn  = ($urandom_range(0, 63) == 0);
            stepCycle(g);
            if (g >= 0) sValid[g] = 0;
        end
        resIn = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
